// File: rtl/rr_packet_arbiter_if.sv
// rr_packet_arbiter_if
// Bundles the request and flit-type inputs and the grant, pop and credit outputs
// of the output-port switch allocator.
//
// Signals:
//   req         per-port flit-valid at the input FIFO head
//   flit_id     per-port flit type, port i at [3i+2:3i]
//   credit_in   one-cycle pulse, the downstream buffer freed one slot
//   grant       one-hot owner of the output port, 0 when idle
//   sel         binary owner index driving the crossbar select, 0 when idle
//   pop         dequeue strobe for each input FIFO head
//   out_valid   a flit crosses the crossbar this cycle
//   busy        the output is locked to one input
//   credits     current downstream credit count
//   timeout_err one-cycle pulse when the watchdog breaks a stalled lock
//
// Modports:
//   master  drives req/flit_id/credit_in (input ports and downstream buffer side)
//   slave   the arbiter itself
interface rr_packet_arbiter_if #(
    parameter int NPORTS = 5
);
    logic [NPORTS-1:0]   req;
    logic [3*NPORTS-1:0] flit_id;
    logic                credit_in;
    logic [NPORTS-1:0]   grant;
    logic [2:0]          sel;
    logic [NPORTS-1:0]   pop;
    logic                out_valid;
    logic                busy;
    logic [2:0]          credits;
    logic                timeout_err;

    modport master (
        output req, flit_id, credit_in,
        input  grant, sel, pop, out_valid, busy, credits, timeout_err
    );

    modport slave (
        input  req, flit_id, credit_in,
        output grant, sel, pop, out_valid, busy, credits, timeout_err
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter
// Round-robin, packet-granular allocator for one router output port shared by
// five input ports (0=L, 1=N, 2=E, 3=W, 4=S). A header flit wins the port, the
// port stays locked to that input until its tail flit leaves, and every flit
// needs a downstream credit to move. A watchdog breaks a lock that has made no
// progress for TIMEOUT consecutive cycles.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   rr_packet_arbiter_if.slave (req, flit_id, credit_in in;
//         grant, sel, pop, out_valid, busy, credits, timeout_err out)
//
// Parameters:
//   NPORTS   number of requesting input ports (the rotation logic assumes 5)
//   CREDITS  downstream buffer depth, initial and maximum credit count
//   TIMEOUT  no-progress cycles in LOCKED before a forced release (1..4095)
module rr_packet_arbiter #(
    parameter int NPORTS  = 5,
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    rr_packet_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [2:0]  CREDITS_MAX  = 3'(CREDITS);
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT - 1);
    localparam logic [3:0]  NPORTS_W     = 4'(NPORTS);
    localparam logic [2:0]  LAST_PORT    = 3'(NPORTS - 1);

    state_t              state_q, state_d;
    logic [NPORTS-1:0]   grant_q, grant_d;
    logic [2:0]          sel_q, sel_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [11:0]         count_q, count_d;
    logic [2:0]          credits_q, credits_d;
    logic                timeout_err_q, timeout_err_d;

    logic [2:0]          head [NPORTS];
    logic [NPORTS-1:0]   cand;
    logic [2*NPORTS-1:0] cand_dbl;
    logic [NPORTS-1:0]   cand_rot;
    logic [2:0]          offset;
    logic [3:0]          win_sum;
    logic [2:0]          win;
    logic                found;

    logic                credit_ok;
    logic                owner_req;
    logic                owner_tail;
    logic [NPORTS-1:0]   pop_c;
    logic                out_valid_c;

    // Split the packed flit_id bus into one 3-bit type per port. Only a flit
    // whose header bit is set can open a packet, so body and tail flits sitting
    // at a FIFO head are invisible to arbitration.
    for (genvar g = 0; g < NPORTS; g++) begin : g_head
        assign head[g] = bus.flit_id[3*g +: 3];
        assign cand[g] = bus.req[g] & head[g][0];
    end

    // Rotate the candidate vector so the port at the round-robin pointer lands
    // in bit 0. Duplicating the vector makes the wrap from port 4 back to port 0
    // fall out of a plain right shift.
    assign cand_dbl = {cand, cand} >> ptr_q;
    assign cand_rot = cand_dbl[NPORTS-1:0];
    assign found    = |cand;

    // First set bit of the rotated vector is the distance from the pointer to
    // the winner. The distance is added back to the pointer modulo the port
    // count to recover the absolute port index.
    always_comb begin
        offset = 3'd0;
        casez (cand_rot)
            5'b????1: offset = 3'd0;
            5'b???10: offset = 3'd1;
            5'b??100: offset = 3'd2;
            5'b?1000: offset = 3'd3;
            5'b10000: offset = 3'd4;
            default:  offset = 3'd0;
        endcase
        win_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (win_sum >= NPORTS_W) begin
            win = 3'(win_sum - NPORTS_W);
        end else begin
            win = win_sum[2:0];
        end
    end

    // Only the owner may dequeue, and only when the downstream buffer has room.
    // Gating pop on credit_ok is also what keeps the credit counter from ever
    // going negative. A header arriving mid-packet on the owner port is simply
    // forwarded like a body flit because only the tail bit is examined here.
    assign credit_ok   = (credits_q != 3'd0);
    assign owner_req   = bus.req[sel_q];
    assign owner_tail  = head[sel_q][2];
    assign pop_c       = (state_q == LOCKED && owner_req && credit_ok)
                         ? (NPORTS'(1) << sel_q) : '0;
    assign out_valid_c = |pop_c;

    // Next-state logic. IDLE grants the first header found from the pointer on
    // and moves the pointer just past the winner. LOCKED releases after the
    // tail has been popped, or when the watchdog has counted TIMEOUT cycles in
    // a row without a pop. A watchdog release leaves the pointer alone, so the
    // stalled owner loses its turn. The tail cycle itself never arbitrates;
    // the next packet is chosen in the IDLE cycle that follows.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    grant_d = NPORTS'(1) << win;
                    sel_d   = win;
                    ptr_d   = (win == LAST_PORT) ? 3'd0 : win + 3'd1;
                    count_d = 12'd0;
                end
            end
            LOCKED: begin
                if (out_valid_c) begin
                    count_d = 12'd0;
                    if (owner_tail) begin
                        state_d = IDLE;
                        grant_d = '0;
                        sel_d   = 3'd0;
                    end
                end else if (count_q == TIMEOUT_LAST) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    sel_d         = 3'd0;
                    count_d       = 12'd0;
                    timeout_err_d = 1'b1;
                end else begin
                    count_d = count_q + 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = 3'd0;
                count_d = 12'd0;
            end
        endcase
    end

    // Credit bookkeeping: a forwarded flit consumes a slot, a credit_in pulse
    // returns one. When both happen together the count stays put, and a return
    // while already full is dropped so the count saturates at the buffer depth.
    always_comb begin
        credits_d = credits_q;
        if (out_valid_c && !bus.credit_in) begin
            credits_d = credits_q - 3'd1;
        end else if (!out_valid_c && bus.credit_in && credits_q != CREDITS_MAX) begin
            credits_d = credits_q + 3'd1;
        end
    end

    // All state lives here. Reset is synchronous and throws away any packet in
    // flight, returning the pointer to port 0 and the credits to full.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            sel_q         <= 3'd0;
            ptr_q         <= 3'd0;
            count_q       <= 12'd0;
            credits_q     <= CREDITS_MAX;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            credits_q     <= credits_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Drive the interface outputs. busy comes straight off the state register.
    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.pop         = pop_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.busy        = (state_q == LOCKED);
    assign bus.credits     = credits_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb_rr_packet_arbiter
// Randomised bench for rr_packet_arbiter. Each input port is fed from a queue
// of whole packets; ports are occasionally held off (which starves an owner
// into the watchdog), or show a stray body flit with no packet behind it.
// Credits return at random, with starved and plentiful phases, and reset is
// sometimes pulsed in the middle of a packet. A packet-level reference model
// (owner / pointer / stall count / credit count as integers) predicts each
// cycle's registered outputs and which flit should leave. A separate monitor
// on the falling edge compares the DUT against those predictions.
module tb_rr_packet_arbiter;

    localparam int NP      = 5;
    localparam int CREDITS = 4;
    localparam int TIMEOUT = 8;
    localparam int NCYC    = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_packet_arbiter_if #(.NPORTS(NP)) bus ();

    rr_packet_arbiter #(
        .NPORTS (NP),
        .CREDITS(CREDITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int         cyc;
        int         port;
    } pop_exp_t;

    typedef struct {
        int         cyc;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic [2:0] credits;
        logic       terr;
    } reg_exp_t;

    typedef logic [2:0] flit_q_t [$];

    pop_exp_t pop_q [$];
    reg_exp_t reg_q [$];
    flit_q_t  fifo [NP];
    int       hold [NP];
    int       junk [NP];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit running  = 1'b0;

    int m_owner;
    int m_ptr;
    int m_stall;
    int m_credits;
    bit m_terr;

    logic [4:0] req_v;
    logic [2:0] flit_v [NP];
    logic       cin_v;

    // Shared comparison: counts every check and reports any difference.
    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Return the reference model and the input sources to their reset state.
    task automatic modelReset();
        m_owner   = -1;
        m_ptr     = 0;
        m_stall   = 0;
        m_credits = CREDITS;
        m_terr    = 1'b0;
        for (int i = 0; i < NP; i++) begin
            fifo[i].delete();
            hold[i] = 0;
            junk[i] = 0;
        end
    endtask

    // Queue one complete packet on port p: either a single-flit packet or a
    // header, 0-2 bodies (rarely a stray header in the body position) and a tail.
    task automatic pushPacket(input int p);
        int len;
        len = int'($urandom_range(1, 4));
        if (len == 1) begin
            fifo[p].push_back(3'b101);
        end else begin
            fifo[p].push_back(3'b001);
            for (int b = 0; b < len - 2; b++) begin
                fifo[p].push_back(($urandom_range(0, 15) == 0) ? 3'b001 : 3'b010);
            end
            fifo[p].push_back(3'b100);
        end
    endtask

    // Drive one cycle of inputs from the port queues and random events.
    task automatic applyStimulus(input int credit_pct);
        logic [14:0] fid;
        for (int i = 0; i < NP; i++) begin
            if (fifo[i].size() < 8 && $urandom_range(0, 99) < 15) pushPacket(i);
            if (hold[i] == 0 && junk[i] == 0 && $urandom_range(0, 99) < 2)
                hold[i] = int'($urandom_range(1, 12));
            if (hold[i] == 0 && junk[i] == 0 && fifo[i].size() == 0 && i != m_owner
                && $urandom_range(0, 99) < 3)
                junk[i] = int'($urandom_range(1, 6));
            if (hold[i] > 0) begin
                req_v[i]  = 1'b0;
                flit_v[i] = 3'($urandom_range(0, 7));
                hold[i]--;
            end else if (junk[i] > 0) begin
                req_v[i]  = 1'b1;
                flit_v[i] = 3'b010;
                junk[i]--;
            end else if (fifo[i].size() > 0) begin
                req_v[i]  = 1'b1;
                flit_v[i] = fifo[i][0];
            end else begin
                req_v[i]  = 1'b0;
                flit_v[i] = 3'($urandom_range(0, 7));
            end
            fid[3*i +: 3] = flit_v[i];
        end
        cin_v         = ($urandom_range(0, 99) < credit_pct);
        rst           = 1'b0;
        bus.req       = req_v;
        bus.flit_id   = fid;
        bus.credit_in = cin_v;
    endtask

    // Record what the registered outputs must show this cycle.
    task automatic pushRegExpect();
        reg_exp_t e;
        e.cyc     = cyc;
        e.grant   = (m_owner >= 0) ? (5'd1 << m_owner) : 5'd0;
        e.sel     = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.busy    = (m_owner >= 0);
        e.credits = 3'(m_credits);
        e.terr    = m_terr;
        reg_q.push_back(e);
    endtask

    // Reference model: predict this cycle's outputs, then advance one cycle.
    task automatic modelStep();
        int       popped;
        int       win;
        int       p;
        logic [2:0] f;
        pop_exp_t pe;
        pushRegExpect();
        popped = -1;
        if (m_owner >= 0 && req_v[m_owner] && m_credits > 0) begin
            popped  = m_owner;
            pe.cyc  = cyc;
            pe.port = m_owner;
            pop_q.push_back(pe);
        end
        m_terr = 1'b0;
        if (m_owner < 0) begin
            win = -1;
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (win < 0 && req_v[p] && flit_v[p][0]) win = p;
            end
            if (win >= 0) begin
                m_owner = win;
                m_ptr   = (win + 1) % NP;
                m_stall = 0;
            end
        end else if (popped >= 0) begin
            m_stall = 0;
            f = fifo[m_owner].pop_front();
            if (f[2]) m_owner = -1;
        end else begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
                m_terr = 1'b1;
                while (fifo[m_owner].size() > 0) begin
                    f = fifo[m_owner].pop_front();
                    if (f[2]) break;
                end
                m_owner = -1;
                m_stall = 0;
            end
        end
        if (popped >= 0 && !cin_v) m_credits--;
        else if (popped < 0 && cin_v && m_credits < CREDITS) m_credits++;
    endtask

    // A cycle with reset asserted; inputs are quiet so nothing may pop.
    task automatic resetCycle();
        @(posedge clk);
        #1;
        cyc++;
        pushRegExpect();
        rst           = 1'b1;
        bus.req       = '0;
        bus.flit_id   = 15'($urandom);
        bus.credit_in = 1'b0;
        modelReset();
    endtask

    // Monitor: compare DUT outputs against the predictions for this cycle.
    task automatic checkOutput();
        reg_exp_t   e;
        pop_exp_t   pe;
        logic [4:0] exp_pop;
        if (reg_q.size() == 0) begin
            expectEq("reg_expect_present", 32'd0, 32'd1);
        end else begin
            e = reg_q.pop_front();
            expectEq("grant", 32'(bus.grant), 32'(e.grant));
            expectEq("sel", 32'(bus.sel), 32'(e.sel));
            expectEq("busy", 32'(bus.busy), 32'(e.busy));
            expectEq("credits", 32'(bus.credits), 32'(e.credits));
            expectEq("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
        end
        exp_pop = 5'd0;
        if (pop_q.size() > 0 && pop_q[0].cyc == cyc) begin
            pe      = pop_q.pop_front();
            exp_pop = 5'd1 << pe.port;
        end
        expectEq("pop", 32'(bus.pop), 32'(exp_pop));
        expectEq("out_valid", 32'(bus.out_valid), 32'(|exp_pop));
    endtask

    always @(negedge clk) begin
        if (running && cyc > 0) checkOutput();
    end

    initial begin
        int pct;
        rst           = 1'b1;
        bus.req       = '0;
        bus.flit_id   = '0;
        bus.credit_in = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        running = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            pct = (((c / 500) % 2) == 1) ? 20 : 70;
            if (m_owner >= 0 && $urandom_range(0, 299) == 0) begin
                resetCycle();
            end else begin
                @(posedge clk);
                #1;
                cyc++;
                applyStimulus(pct);
                modelStep();
            end
        end
        @(negedge clk);
        #1;
        running = 1'b0;
        expectEq("pop_queue_drained", 32'(pop_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
